button_event_arbiter: RTL and testbench
=======================================

# button_event_arbiter

Multi-channel front end that synchronizes and debounces N raw mechanical inputs, detects edges on each debounced level, and queues the resulting edge events per channel. A round-robin arbiter serializes all channels' events onto one valid/ready event port. It sits between board pins and the control logic, which consumes one event at a time.

## Interface
- N, 4: number of input channels (2..16).
- CNT_W, 16: debounce counter width.
- DB_COUNT, 50000: consecutive cycles a synchronized input must differ from the debounced level before the level toggles. Must satisfy 1 ≤ DB_COUNT < 2^CNT_W.

Ports:
- clk  in  1  single clock; all flops on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in  in  N  raw asynchronous inputs.
- ev_ready  in  1  consumer accepts the event.
- clr_ovf  in  1  synchronous clear of all ovf bits.
- ev_valid  out  1  event offered; reset 0.
- ev_chan  out  clog2(N)  channel of the offered event; reset 0.
- ev_rise  out  1  1 = rising edge, 0 = falling edge; reset 0.
- level  out  N  debounced levels; reset 0.
- ovf  out  N  sticky per-channel event-drop flags; reset 0.

## Operation
- **Sync:** 2-flop synchronizer per channel (sync1, sync2), reset 0.
- **Debounce:** per-channel counter.
  - Counts edges where sync2 ≠ level.
  - Clears on any edge where sync2 == level.
  - At the edge where it would reach DB_COUNT, level toggles and the counter clears.
- **Edge:** level 0→1 produces a rise event; 1→0 produces a fall event (fall only with FALL_EVENTS_EN). The event is enqueued on the same edge the level toggles.
- **Per-channel queue:** count 0..2 plus head type bit.
  - Second entry's type is ~head with FALL_EVENTS_EN, and rise without it.
  - Event arriving with count==2 and no same-cycle accept on that channel: dropped, ovf[ch] set.
  - Enqueue and accept on the same channel in the same cycle: count unchanged; the head advances correctly and no overflow occurs.
- **Arbiter FSM:**
  - IDLE: if any count > 0, select the first channel with count > 0, searching from ptr upward mod N. Load ev_chan and ev_rise (head type), then go to OFFER.
  - OFFER: ev_valid=1 with ev_chan and ev_rise held stable. On ev_valid & ev_ready:
    - decrement that channel's count;
    - head becomes ~head (FALL_EVENTS_EN) or rise;
    - ptr = ev_chan+1 mod N;
    - go to IDLE.
  - ev_valid never drops without acceptance.
- **ovf:** clr_ovf clears all bits. A same-cycle set overrides the clear for that channel.
- **Reset mid-operation:** all state, queues, counters, ptr and outputs go to reset values immediately. An input held high through reset generates one rise event after debounce.

## Timing
- Raw change captured at edge k:
  - level toggles at edge k+1+DB_COUNT;
  - ev_valid rises at edge k+2+DB_COUNT (queue was empty, FSM in IDLE).
- Accept takes one cycle (ev_ready high while ev_valid high). ev_valid is low for at least one cycle between events. Peak throughput: one event per 2 cycles.
- All outputs are registered; no combinational path from in or ev_ready to outputs.

## Configuration
- FALL_EVENTS_EN defined:
  - falling edges enqueue fall events (ev_rise=0);
  - queue entries alternate type.
- Undefined:
  - falling edges only update level;
  - ev_rise is always 1;
  - queue holds up to 2 rise events.

## Test plan
All scenarios use N=4, DB_COUNT=4.
- **Clean rise:** in[0] 0→1 before edge 10, ev_ready=1 → level[0]=1 at edge 15; ev_valid=1, ev_chan=0, ev_rise=1 at edge 16; ev_valid=0 at edge 17.
- **Glitch rejection:** in[1] high for 3 cycles then low → level[1] stays 0, no event, counter back to 0.
- **Round robin:** ch0, ch1 and ch3 rise simultaneously, ptr=0, ev_ready=1 → events ch0, ch1, ch3 on alternate cycles; ptr ends at 0. Then ch3 and ch0 rise together → ch0 first.
- **Backpressure and overflow (FALL_EVENTS_EN):** ev_ready=0; in[2] toggles rise, fall, rise with 8-cycle spacing → count[2]=2, ovf[2]=1. Raise ev_ready → rise, then fall on ch2; no third event. Pulse clr_ovf → ovf[2]=0.
- **Macro off:** in[0] rise then fall → single event with ev_rise=1; level[0] returns to 0 with no event.
- **Reset mid-offer:** ev_valid=1, ev_ready=0, assert reset_n=0 → ev_valid, level, ovf and queues are 0 immediately; no event after release until new debounced edges occur.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Synchronizes, debounces and edge-detects N raw inputs, queues up to two events per channel
// and round-robins them onto one valid/ready port. Define FALL_EVENTS_EN to also report falling edges.
module button_event_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DB_COUNT = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         in,
    input  logic                 ev_ready,
    input  logic                 clr_ovf,
    output logic                 ev_valid,
    output logic [$clog2(N)-1:0] ev_chan,
    output logic                 ev_rise,
    output logic [N-1:0]         level,
    output logic [N-1:0]         ovf
);
    localparam int unsigned CW = $clog2(N);
`ifdef FALL_EVENTS_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t           r_state;
    logic [N-1:0]     r_sync1;
    logic [N-1:0]     r_sync2;
    logic [N-1:0]     r_head;
    logic [CNT_W-1:0] r_cnt  [N];
    logic [1:0]       r_qcnt [N];
    logic [CW-1:0]    r_ptr;

    logic [N-1:0]     w_toggle;
    logic [N-1:0]     w_enq;
    logic [N-1:0]     w_etype;
    logic [N-1:0]     w_deq;
    logic [N-1:0]     w_adv;
    logic [N-1:0]     w_drop;
    logic [N-1:0]     w_nonempty;
    logic             w_accept;
    logic             w_found;
    logic [CW-1:0]    w_sel;
    logic [CW:0]      w_idx;

    // Two-flop synchronizer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    // Per-channel level toggle, event generation and queue handshake terms
    always_comb begin
        w_accept   = ev_valid & ev_ready;
        w_toggle   = '0;
        w_enq      = '0;
        w_etype    = '0;
        w_deq      = '0;
        w_adv      = '0;
        w_drop     = '0;
        w_nonempty = '0;
        for (int i = 0; i < N; i++) begin
            w_toggle[i]   = (r_sync2[i] != level[i]) && (r_cnt[i] == CNT_W'(DB_COUNT - 1));
            w_etype[i]    = FALL_EN ? ~level[i] : 1'b1;
            w_enq[i]      = FALL_EN ? w_toggle[i] : (w_toggle[i] & ~level[i]);
            w_deq[i]      = w_accept && (ev_chan == CW'(i));
            w_adv[i]      = FALL_EN ? ~r_head[i] : 1'b1;
            w_drop[i]     = w_enq[i] && !w_deq[i] && (r_qcnt[i] == 2'd2);
            w_nonempty[i] = (r_qcnt[i] != 2'd0);
        end
    end

    // Debounce counters and debounced levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (r_sync2[i] == level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_toggle[i]) begin
                    r_cnt[i] <= '0;
                    level[i] <= ~level[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Two-deep queues: only the head type is stored, the second entry's type is implied
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            ovf    <= '0;
            for (int i = 0; i < N; i++) r_qcnt[i] <= 2'd0;
        end else begin
            ovf <= (clr_ovf ? '0 : ovf) | w_drop;
            for (int i = 0; i < N; i++) begin
                if (w_enq[i] && w_deq[i]) begin
                    r_head[i] <= (r_qcnt[i] == 2'd1) ? w_etype[i] : w_adv[i];
                end else if (w_enq[i]) begin
                    if (r_qcnt[i] == 2'd0) begin
                        r_head[i] <= w_etype[i];
                        r_qcnt[i] <= 2'd1;
                    end else if (r_qcnt[i] == 2'd1) begin
                        r_qcnt[i] <= 2'd2;
                    end
                end else if (w_deq[i]) begin
                    r_qcnt[i] <= r_qcnt[i] - 2'd1;
                    r_head[i] <= w_adv[i];
                end
            end
        end
    end

    // First non-empty channel at or after the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, r_ptr} + (CW+1)'(i);
            if (w_idx >= (CW+1)'(N)) w_idx = w_idx - (CW+1)'(N);
            if (!w_found && w_nonempty[w_idx[CW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[CW-1:0];
            end
        end
    end

    // Arbiter: offer one event, hold it until accepted, then return to idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            ev_valid <= 1'b0;
            ev_chan  <= '0;
            ev_rise  <= 1'b0;
            r_ptr    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        ev_valid <= 1'b1;
                        ev_chan  <= w_sel;
                        ev_rise  <= r_head[w_sel];
                        r_state  <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (ev_ready) begin
                        ev_valid <= 1'b0;
                        r_ptr    <= (ev_chan == CW'(N - 1)) ? '0 : ev_chan + CW'(1);
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: a window-based reference model predicts levels,
// queue contents and offered events; a monitor compares the DUT against it every cycle.
module tb_button_event_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DB = 4;
`ifdef FALL_EVENTS_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] chan;
        logic       rise;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_r = '0;
    logic         ready_r = 1'b0;
    logic         clr_r = 1'b0;
    logic         ev_valid;
    logic [1:0]   ev_chan;
    logic         ev_rise;
    logic [N-1:0] level;
    logic [N-1:0] ovf;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [N-1:0] hist[$];
    int           last_t [N];
    int           qlen [N];
    bit           qv [N][2];
    bit [N-1:0]   m_level = '0;
    bit [N-1:0]   m_ovf = '0;
    bit           m_valid = 1'b0;
    int           m_chan = 0;
    int           m_ptr = 0;
    ev_t          exp_q[$];

    button_event_arbiter #(.N(N), .CNT_W(8), .DB_COUNT(DB)) dut (
        .clk      (clk),
        .reset_n  (rst_n),
        .in       (in_r),
        .ev_ready (ready_r),
        .clr_ovf  (clr_r),
        .ev_valid (ev_valid),
        .ev_chan  (ev_chan),
        .ev_rise  (ev_rise),
        .level    (level),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a level flips once the synchronized input has disagreed with it
    // for DB consecutive edges since the last flip; sync2 before edge e is the raw value
    // captured at edge e-2.
    always @(posedge clk or negedge rst_n) begin : model
        bit         acc;
        int         acc_ch;
        int         e;
        int         c;
        int         idx;
        bit         s;
        bit         tog;
        bit         nl;
        bit         t;
        bit [N-1:0] drop;
        ev_t        ev;
        if (!rst_n) begin
            hist.delete();
            exp_q.delete();
            for (int i = 0; i < N; i++) begin
                last_t[i] = -1000;
                qlen[i]   = 0;
            end
            m_level = '0;
            m_ovf   = '0;
            m_valid = 1'b0;
            m_chan  = 0;
            m_ptr   = 0;
        end else begin
            acc    = m_valid && ready_r;
            acc_ch = m_chan;
            hist.push_back(in_r);
            e    = hist.size() - 1;
            drop = '0;
            if (!m_valid) begin
                for (int j = 0; j < N; j++) begin
                    c = (m_ptr + j) % N;
                    if (qlen[c] > 0) begin
                        m_valid = 1'b1;
                        m_chan  = c;
                        ev.chan = 2'(c);
                        ev.rise = qv[c][0];
                        exp_q.push_back(ev);
                        break;
                    end
                end
            end else if (ready_r) begin
                m_valid = 1'b0;
                m_ptr   = (m_chan + 1) % N;
            end
            for (int ch = 0; ch < N; ch++) begin
                tog = (e - last_t[ch] >= int'(DB));
                for (int j = 0; j < int'(DB); j++) begin
                    idx = e - 2 - j;
                    s   = (idx >= 0) ? hist[idx][ch] : 1'b0;
                    if (s == m_level[ch]) tog = 1'b0;
                end
                if (acc && acc_ch == ch) begin
                    qv[ch][0] = qv[ch][1];
                    qlen[ch]--;
                end
                if (tog) begin
                    nl = ~m_level[ch];
                    if (FALL_EN || nl) begin
                        t = FALL_EN ? nl : 1'b1;
                        if (qlen[ch] == 0) begin
                            qv[ch][0] = t;
                            qlen[ch]  = 1;
                        end else if (qlen[ch] == 1) begin
                            qv[ch][1] = FALL_EN ? ~qv[ch][0] : 1'b1;
                            qlen[ch]  = 2;
                        end else begin
                            drop[ch] = 1'b1;
                        end
                    end
                    m_level[ch] = nl;
                    last_t[ch]  = e;
                end
            end
            m_ovf = (clr_r ? '0 : m_ovf) | drop;
        end
    end

    // Monitor: per-cycle outputs against the model, offered events against the scoreboard
    always begin : monitor
        bit  prev_valid;
        ev_t cur;
        prev_valid = 1'b0;
        cur        = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                chk("ev_valid", int'(ev_valid), int'(m_valid));
                chk("level", int'(level), int'(m_level));
                chk("ovf", int'(ovf), int'(m_ovf));
                if (ev_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL sb_unexpected: got event chan %0d rise %0d expected none at %0t",
                                 ev_chan, ev_rise, $time);
                        cur.chan = ev_chan;
                        cur.rise = ev_rise;
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                if (ev_valid) begin
                    chk("ev_chan", int'(ev_chan), int'(cur.chan));
                    chk("ev_rise", int'(ev_rise), int'(cur.rise));
                end
                prev_valid = ev_valid;
            end
        end
    end

    initial begin : stim
        bit got;
        in_r    = '0;
        ready_r = 1'b1;
        clr_r   = 1'b0;
        rst_n   = 1'b0;
        cyc(3);
        chk("rst_ev_valid", int'(ev_valid), 0);
        chk("rst_ev_chan", int'(ev_chan), 0);
        chk("rst_ev_rise", int'(ev_rise), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;

        // clean rise, then a 3-cycle glitch
        cyc(2);
        in_r[0] = 1'b1;
        cyc(12);
        in_r[1] = 1'b1;
        cyc(3);
        in_r[1] = 1'b0;
        cyc(10);

        // simultaneous rises for round robin
        in_r = '0;
        cyc(12);
        in_r = 4'b1011;
        cyc(16);
        in_r = '0;
        cyc(12);
        in_r = 4'b1001;
        cyc(16);
        in_r = '0;
        cyc(12);

        // backpressure into overflow, drain, then clear
        ready_r = 1'b0;
        repeat (6) begin
            in_r[2] = ~in_r[2];
            cyc(8);
        end
        ready_r = 1'b1;
        cyc(20);
        clr_r = 1'b1;
        cyc(1);
        clr_r = 1'b0;
        cyc(4);

        // reset while an event is being offered
        in_r = '0;
        cyc(12);
        ready_r = 1'b0;
        in_r[2] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            cyc(1);
            got = ev_valid;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL offer_timeout: got ev_valid 0 expected 1 within 50 cycles");
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_ev_valid", int'(ev_valid), 0);
        chk("midrst_level", int'(level), 0);
        chk("midrst_ovf", int'(ovf), 0);
        cyc(3);
        rst_n   = 1'b1;
        ready_r = 1'b1;
        cyc(20);

        // randomized inputs, handshake and clears
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < int'(N); ch++)
                if ($urandom_range(0, 11) == 0) in_r[ch] = ~in_r[ch];
            ready_r = ($urandom_range(0, 3) != 0) && ((i / 150) % 3 != 2);
            clr_r   = ($urandom_range(0, 40) == 0);
            cyc(1);
        end

        // drain
        clr_r   = 1'b0;
        ready_r = 1'b1;
        cyc(40);
        chk("drain_sb_empty", exp_q.size(), 0);
        chk("drain_ev_valid", int'(ev_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
